// File: rtl/idma_obi_beat_splitter_if.sv
// Bus bundle of the iDMA OBI beat splitter: transfer request in, read/write beat streams out.
// The slave modport is the splitter's view, the master modport is the driver/consumer view.
interface idma_obi_beat_splitter_if #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned LenWidth  = 32
);
    localparam int unsigned OffW = $clog2(DataWidth / 8);

    logic                 req_valid_i;
    logic                 req_ready_o;
    logic [AddrWidth-1:0] req_src_addr_i;
    logic [AddrWidth-1:0] req_dst_addr_i;
    logic [LenWidth-1:0]  req_length_i;

    logic                 r_valid_o;
    logic                 r_ready_i;
    logic [AddrWidth-1:0] r_addr_o;
    logic [OffW-1:0]      r_offset_o;
    logic [OffW-1:0]      r_tailer_o;
    logic [OffW-1:0]      r_shift_o;
    logic                 r_last_o;

    logic                 w_valid_o;
    logic                 w_ready_i;
    logic [AddrWidth-1:0] w_addr_o;
    logic [OffW-1:0]      w_offset_o;
    logic [OffW-1:0]      w_tailer_o;
    logic                 w_last_o;

    logic                 busy_o;

    modport slave (
        input  req_valid_i, req_src_addr_i, req_dst_addr_i, req_length_i,
        output req_ready_o,
        output r_valid_o, r_addr_o, r_offset_o, r_tailer_o, r_shift_o, r_last_o,
        input  r_ready_i,
        output w_valid_o, w_addr_o, w_offset_o, w_tailer_o, w_last_o,
        input  w_ready_i,
        output busy_o
    );

    modport master (
        output req_valid_i, req_src_addr_i, req_dst_addr_i, req_length_i,
        input  req_ready_o,
        input  r_valid_o, r_addr_o, r_offset_o, r_tailer_o, r_shift_o, r_last_o,
        output r_ready_i,
        input  w_valid_o, w_addr_o, w_offset_o, w_tailer_o, w_last_o,
        output w_ready_i,
        input  busy_o
    );
endinterface

// File: rtl/idma_obi_beat_splitter.sv
// Splits one 1D transfer into independent streams of bus-word read and write beats,
// each beat carrying its word address and valid byte-lane window.
module idma_obi_beat_splitter #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned LenWidth  = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    idma_obi_beat_splitter_if.slave   bus
);
    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned OffW      = $clog2(StrbWidth);

    logic                 r_active_q, r_active_d, w_active_q, w_active_d;
    logic [AddrWidth-1:0] r_a_q, r_a_d, w_a_q, w_a_d;
    logic [LenWidth-1:0]  r_rem_q, r_rem_d, w_rem_q, w_rem_d;
    logic [OffW-1:0]      r_shift_q, r_shift_d;

    logic [OffW-1:0]      r_off_s, w_off_s, r_tail_s, w_tail_s;
    logic [OffW:0]        r_space_s, w_space_s, r_bytes_s, w_bytes_s;
    logic                 r_last_s, w_last_s;
    logic [AddrWidth-1:0] r_base_s, w_base_s;
    logic                 req_ready_s, accept_s, r_hs_s, w_hs_s;

    // Per-side beat window: bytes is clipped to the lanes left in the current word.
    always_comb begin
        r_off_s   = r_a_q[OffW-1:0];
        w_off_s   = w_a_q[OffW-1:0];
        r_space_s = (OffW+1)'(StrbWidth) - {1'b0, r_off_s};
        w_space_s = (OffW+1)'(StrbWidth) - {1'b0, w_off_s};
        if (r_rem_q < LenWidth'(r_space_s)) begin
            r_bytes_s = r_rem_q[OffW:0];
        end else begin
            r_bytes_s = r_space_s;
        end
        if (w_rem_q < LenWidth'(w_space_s)) begin
            w_bytes_s = w_rem_q[OffW:0];
        end else begin
            w_bytes_s = w_space_s;
        end
        r_tail_s = r_off_s + r_bytes_s[OffW-1:0];
        w_tail_s = w_off_s + w_bytes_s[OffW-1:0];
        r_last_s = (r_rem_q == LenWidth'(r_bytes_s));
        w_last_s = (w_rem_q == LenWidth'(w_bytes_s));
        r_base_s = {r_a_q[AddrWidth-1:OffW], {OffW{1'b0}}};
        w_base_s = {w_a_q[AddrWidth-1:OffW], {OffW{1'b0}}};
    end

    assign req_ready_s = ~rst_i & ~r_active_q & ~w_active_q;
    assign accept_s    = bus.req_valid_i & req_ready_s;
    assign r_hs_s      = r_active_q & bus.r_ready_i;
    assign w_hs_s      = w_active_q & bus.w_ready_i;

    // Next-state: a new transfer loads both sides; otherwise each side advances on its handshake.
    always_comb begin
        r_active_d = r_active_q;
        r_a_d      = r_a_q;
        r_rem_d    = r_rem_q;
        r_shift_d  = r_shift_q;
        w_active_d = w_active_q;
        w_a_d      = w_a_q;
        w_rem_d    = w_rem_q;
        if (accept_s) begin
            r_a_d      = bus.req_src_addr_i;
            w_a_d      = bus.req_dst_addr_i;
            r_rem_d    = bus.req_length_i;
            w_rem_d    = bus.req_length_i;
            r_active_d = (bus.req_length_i != '0);
            w_active_d = (bus.req_length_i != '0);
            r_shift_d  = bus.req_src_addr_i[OffW-1:0] - bus.req_dst_addr_i[OffW-1:0];
        end else begin
            if (r_hs_s) begin
                r_a_d      = r_base_s + AddrWidth'(StrbWidth);
                r_rem_d    = r_rem_q - LenWidth'(r_bytes_s);
                r_active_d = ~r_last_s;
            end else begin
                r_a_d      = r_a_q;
            end
            if (w_hs_s) begin
                w_a_d      = w_base_s + AddrWidth'(StrbWidth);
                w_rem_d    = w_rem_q - LenWidth'(w_bytes_s);
                w_active_d = ~w_last_s;
            end else begin
                w_a_d      = w_a_q;
            end
        end
    end

    // Side-engine state registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_active_q <= 1'b0;
            r_a_q      <= '0;
            r_rem_q    <= '0;
            r_shift_q  <= '0;
            w_active_q <= 1'b0;
            w_a_q      <= '0;
            w_rem_q    <= '0;
        end else begin
            r_active_q <= r_active_d;
            r_a_q      <= r_a_d;
            r_rem_q    <= r_rem_d;
            r_shift_q  <= r_shift_d;
            w_active_q <= w_active_d;
            w_a_q      <= w_a_d;
            w_rem_q    <= w_rem_d;
        end
    end

    // Outputs read 0 while reset is asserted; last is qualified by active so idle reads 0.
    assign bus.req_ready_o = req_ready_s;
    assign bus.r_valid_o   = r_active_q & ~rst_i;
    assign bus.r_addr_o    = rst_i ? '0 : r_base_s;
    assign bus.r_offset_o  = rst_i ? '0 : r_off_s;
    assign bus.r_tailer_o  = rst_i ? '0 : r_tail_s;
    assign bus.r_shift_o   = rst_i ? '0 : r_shift_q;
    assign bus.r_last_o    = r_active_q & r_last_s & ~rst_i;
    assign bus.w_valid_o   = w_active_q & ~rst_i;
    assign bus.w_addr_o    = rst_i ? '0 : w_base_s;
    assign bus.w_offset_o  = rst_i ? '0 : w_off_s;
    assign bus.w_tailer_o  = rst_i ? '0 : w_tail_s;
    assign bus.w_last_o    = w_active_q & w_last_s & ~rst_i;
    assign bus.busy_o      = (r_active_q | w_active_q) & ~rst_i;
endmodule
